// File: rtl/trace_capture_ctrl.sv
// ---------------------------------------------------------------------------
// trace_capture_ctrl
//
// Purpose
//   Sequences a single trace capture into a dual-port trace buffer BRAM.
//   After arm, samples are written circularly (pre-trigger history). A trigger
//   latches the trigger address and a post-trigger sample count. When that many
//   further samples have been written, the buffer is frozen for host readout.
//   Port A (write side) is driven from the sample strobe. Port B (read side) is
//   driven from host offsets that are relative to the oldest captured sample.
//
// Parameters
//   ADDR_WIDTH  BRAM address width; buffer depth is 2**ADDR_WIDTH entries
//   RD_LATENCY  BRAM port-B read latency in clk cycles (>= 1)
//
// Ports
//   clk             in   clock
//   rstn            in   asynchronous active-low reset
//   arm             in   pulse: start a new capture (honoured in IDLE/DONE)
//   abort           in   pulse: return to IDLE from any state
//   trigger         in   trigger event (honoured in ARMED only)
//   sample_valid    in   one-cycle sample strobe
//   post_count      in   post-trigger samples to write, sampled at trigger
//   host_rd_req     in   host read request (honoured in DONE only)
//   host_rd_offset  in   read offset from the oldest captured sample
//   bram_en         out  BRAM enable, constant 1
//   bram_we         out  port-A write enable (registered)
//   bram_addra      out  port-A write address (registered)
//   bram_addrb      out  port-B read address (registered)
//   host_rd_valid   out  read data valid, RD_LATENCY+1 cycles after the request
//   state           out  0 IDLE, 1 ARMED, 2 POST, 3 DONE
//   done            out  high while in DONE
//   wrapped         out  write pointer wrapped at least once this capture
//   trig_addr       out  address of the first post-trigger sample
//   start_addr      out  address of the oldest valid sample (meaningful in DONE)
//   captured        out  number of valid samples (meaningful in DONE)
//
// The sample data must be delayed by one cycle by the integrator, because the
// write strobe and write address appear one cycle after sample_valid.
// ---------------------------------------------------------------------------
module trace_capture_ctrl #(
   parameter int ADDR_WIDTH = 15,
   parameter int RD_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  arm,
   input  logic                  abort,
   input  logic                  trigger,
   input  logic                  sample_valid,
   input  logic [ADDR_WIDTH-1:0] post_count,
   input  logic                  host_rd_req,
   input  logic [ADDR_WIDTH-1:0] host_rd_offset,
   output logic                  bram_en,
   output logic                  bram_we,
   output logic [ADDR_WIDTH-1:0] bram_addra,
   output logic [ADDR_WIDTH-1:0] bram_addrb,
   output logic                  host_rd_valid,
   output logic [1:0]            state,
   output logic                  done,
   output logic                  wrapped,
   output logic [ADDR_WIDTH-1:0] trig_addr,
   output logic [ADDR_WIDTH-1:0] start_addr,
   output logic [ADDR_WIDTH:0]   captured
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_POST  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] CNT_ZERO = '0;
   localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0]   DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};

   state_t                r_state;
   state_t                w_next_state;

   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_post_cnt;
   logic                  r_wrapped;
   logic [ADDR_WIDTH-1:0] r_trig_addr;
   logic                  r_bram_we;
   logic [ADDR_WIDTH-1:0] r_bram_addra;
   logic [ADDR_WIDTH-1:0] r_bram_addrb;
   logic [RD_LATENCY:0]   r_rd_pipe;

   logic                  w_accept;     // sample written this cycle
   logic                  w_trig_load;  // latch trigger address / post count
   logic                  w_clear;      // start of a fresh capture
   logic                  w_rd_accept;  // host read accepted this cycle
   logic [ADDR_WIDTH-1:0] w_start_addr;

   // Oldest valid sample: once the pointer has wrapped, the next location to be
   // written holds the oldest surviving sample.
   assign w_start_addr = r_wrapped ? r_wr_ptr : CNT_ZERO;

   // ---- state register ----
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ---- next state and per-cycle control ----
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_trig_load  = 1'b0;
      w_clear      = 1'b0;
      w_rd_accept  = 1'b0;

      // abort overrides arm, trigger, samples and reads in the same cycle
      if (abort) begin
         w_next_state = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (arm) begin
                  w_next_state = S_ARMED;
                  w_clear      = 1'b1;
               end
            end

            S_ARMED: begin
               if (trigger) begin
                  w_trig_load = 1'b1;
                  if (post_count == CNT_ZERO) begin
                     // nothing to write after the trigger: freeze immediately
                     w_next_state = S_DONE;
                  end else begin
                     // a coincident sample is the first post-trigger sample
                     w_accept = sample_valid;
                     if (sample_valid && (post_count == CNT_ONE)) begin
                        w_next_state = S_DONE;
                     end else begin
                        w_next_state = S_POST;
                     end
                  end
               end else begin
                  w_accept = sample_valid;
               end
            end

            S_POST: begin
               if (sample_valid) begin
                  w_accept = 1'b1;
                  // the last write is issued together with the move to DONE
                  if (r_post_cnt == CNT_ONE) begin
                     w_next_state = S_DONE;
                  end
               end
            end

            S_DONE: begin
               w_rd_accept = host_rd_req;
               if (arm) begin
                  w_next_state = S_ARMED;
                  w_clear      = 1'b1;
               end
            end

            default: begin
               w_next_state = S_IDLE;
            end
         endcase
      end
   end

   // ---- write side (port A) and capture bookkeeping ----
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_ptr     <= '0;
         r_post_cnt   <= '0;
         r_wrapped    <= 1'b0;
         r_trig_addr  <= '0;
         r_bram_we    <= 1'b0;
         r_bram_addra <= '0;
      end else begin
         r_bram_we <= w_accept;

         if (w_accept) begin
            r_bram_addra <= r_wr_ptr;
            r_wr_ptr     <= r_wr_ptr + CNT_ONE;
            if (r_wr_ptr == {ADDR_WIDTH{1'b1}}) begin
               r_wrapped <= 1'b1;
            end
         end

         if (w_clear) begin
            r_wr_ptr    <= '0;
            r_wrapped   <= 1'b0;
            r_trig_addr <= '0;
         end

         if (w_trig_load) begin
            r_trig_addr <= r_wr_ptr;
            // a coincident sample already consumes one of the post samples
            r_post_cnt  <= post_count - ADDR_WIDTH'(w_accept);
         end else if (w_accept && (r_state == S_POST)) begin
            r_post_cnt  <= r_post_cnt - CNT_ONE;
         end
      end
   end

   // ---- read side (port B) and valid pipeline ----
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_bram_addrb <= '0;
         r_rd_pipe    <= '0;
      end else begin
         if (w_rd_accept) begin
            r_bram_addrb <= w_start_addr + host_rd_offset;
         end
         // abort drops any reads still in flight; arm lets them complete
         if (abort) begin
            r_rd_pipe <= '0;
         end else begin
            r_rd_pipe <= {r_rd_pipe[RD_LATENCY-1:0], w_rd_accept};
         end
      end
   end

   assign bram_en       = 1'b1;
   assign bram_we       = r_bram_we;
   assign bram_addra    = r_bram_addra;
   assign bram_addrb    = r_bram_addrb;
   assign host_rd_valid = r_rd_pipe[RD_LATENCY];
   assign state         = r_state;
   assign done          = (r_state == S_DONE);
   assign wrapped       = r_wrapped;
   assign trig_addr     = r_trig_addr;
   assign start_addr    = w_start_addr;
   assign captured      = r_wrapped ? DEPTH : {1'b0, r_wr_ptr};

endmodule

// File: tb/tb_trace_capture_ctrl.sv
module tb_trace_capture_ctrl;

   localparam int AW    = 4;
   localparam int RL    = 2;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rstn;
   logic          arm, abort, trigger, sample_valid, host_rd_req;
   logic [AW-1:0] post_count, host_rd_offset;
   logic          bram_en, bram_we, host_rd_valid, done, wrapped;
   logic [AW-1:0] bram_addra, bram_addrb, trig_addr, start_addr;
   logic [1:0]    state;
   logic [AW:0]   captured;

   int checks = 0;
   int errors = 0;

   trace_capture_ctrl #(.ADDR_WIDTH(AW), .RD_LATENCY(RL)) dut (
      .clk(clk), .rstn(rstn), .arm(arm), .abort(abort), .trigger(trigger),
      .sample_valid(sample_valid), .post_count(post_count),
      .host_rd_req(host_rd_req), .host_rd_offset(host_rd_offset),
      .bram_en(bram_en), .bram_we(bram_we), .bram_addra(bram_addra),
      .bram_addrb(bram_addrb), .host_rd_valid(host_rd_valid), .state(state),
      .done(done), .wrapped(wrapped), .trig_addr(trig_addr),
      .start_addr(start_addr), .captured(captured)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endfunction

   // ---------------- behavioural model ----------------
   // phase: 0 idle, 1 armed, 2 post, 3 done. Reads are tracked as the edge
   // number at which their valid pulse is due.
   int m_phase, m_ptr, m_wrap, m_trig, m_rem;
   int m_we, m_addra, m_addrb, m_valid, m_edge;
   int m_rdq[$];

   function automatic int m_start();
      return m_wrap ? m_ptr : 0;
   endfunction

   function automatic int m_captured();
      return m_wrap ? DEPTH : m_ptr;
   endfunction

   function automatic void m_write();
      m_we    = 1;
      m_addra = m_ptr;
      m_ptr   = (m_ptr + 1) % DEPTH;
      if (m_ptr == 0) m_wrap = 1;
   endfunction

   function automatic void m_rearm();
      m_phase = 1;
      m_ptr   = 0;
      m_wrap  = 0;
      m_trig  = 0;
   endfunction

   task automatic model_step();
      if (!rstn) begin
         m_phase = 0; m_ptr = 0; m_wrap = 0; m_trig = 0; m_rem = 0;
         m_we = 0; m_addra = 0; m_addrb = 0; m_valid = 0;
         m_rdq.delete();
      end else begin
         m_edge++;
         m_we    = 0;
         m_valid = 0;
         if (abort) begin
            m_rdq.delete();
            m_phase = 0;
         end else begin
            if (m_rdq.size() > 0 && m_rdq[0] == m_edge) begin
               m_valid = 1;
               void'(m_rdq.pop_front());
            end
            case (m_phase)
               0: if (arm) m_rearm();
               1: begin
                  if (trigger) begin
                     m_trig = m_ptr;
                     if (post_count == 0) begin
                        m_phase = 3;
                     end else begin
                        m_rem = int'(post_count);
                        if (sample_valid) begin
                           m_write();
                           m_rem--;
                        end
                        m_phase = (m_rem == 0) ? 3 : 2;
                     end
                  end else if (sample_valid) begin
                     m_write();
                  end
               end
               2: if (sample_valid) begin
                  m_write();
                  m_rem--;
                  if (m_rem == 0) m_phase = 3;
               end
               default: begin
                  if (host_rd_req) begin
                     m_addrb = (m_start() + int'(host_rd_offset)) % DEPTH;
                     m_rdq.push_back(m_edge + RL);
                  end
                  if (arm) m_rearm();
               end
            endcase
         end
      end
   endtask

   initial forever begin
      @(posedge clk or negedge rstn);
      model_step();
   end

   // ---------------- per-cycle compare ----------------
   initial forever begin
      @(negedge clk);
      chk("state", int'(state), m_phase);
      chk("done", int'(done), int'(m_phase == 3));
      chk("bram_en", int'(bram_en), 1);
      chk("bram_we", int'(bram_we), m_we);
      chk("bram_addra", int'(bram_addra), m_addra);
      chk("bram_addrb", int'(bram_addrb), m_addrb);
      chk("host_rd_valid", int'(host_rd_valid), m_valid);
      chk("wrapped", int'(wrapped), m_wrap);
      chk("trig_addr", int'(trig_addr), m_trig);
      if (m_phase == 3) begin
         chk("start_addr", int'(start_addr), m_start());
         chk("captured", int'(captured), m_captured());
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #3;
   endtask

   task automatic samples(input int n);
      for (int i = 0; i < n; i++) begin
         sample_valid = 1'b1;
         tick();
         sample_valid = 1'b0;
         tick();
      end
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic do_trigger(input int pc);
      trigger    = 1'b1;
      post_count = AW'(pc);
      tick();
      trigger    = 1'b0;
   endtask

   initial begin
      rstn = 1'b0; arm = 1'b0; abort = 1'b0; trigger = 1'b0;
      sample_valid = 1'b0; host_rd_req = 1'b0;
      post_count = '0; host_rd_offset = '0;
      tick(); tick();
      chk("rst_state", int'(state), 0);
      chk("rst_bram_en", int'(bram_en), 1);
      chk("rst_captured", int'(captured), 0);
      rstn = 1'b1;
      tick();

      // no wrap: 5 pre, trigger, 3 post
      pulse_arm();
      samples(5);
      do_trigger(3);
      samples(3);
      chk("nw_trig_addr", int'(trig_addr), 5);
      chk("nw_start_addr", int'(start_addr), 0);
      chk("nw_captured", int'(captured), 8);
      chk("nw_wrapped", int'(wrapped), 0);
      chk("nw_done", int'(done), 1);
      chk("nw_last_addra", int'(bram_addra), 7);

      // wrap: 20 pre, trigger, 4 post, then back-to-back reads
      pulse_arm();
      samples(20);
      do_trigger(4);
      samples(4);
      chk("w_wrapped", int'(wrapped), 1);
      chk("w_start_addr", int'(start_addr), 8);
      chk("w_captured", int'(captured), 16);
      host_rd_req = 1'b1; host_rd_offset = 4'd0;
      tick();
      chk("w_addrb_off0", int'(bram_addrb), 8);
      chk("w_valid_early0", int'(host_rd_valid), 0);
      host_rd_offset = 4'd15;
      tick();
      chk("w_addrb_off15", int'(bram_addrb), 7);
      chk("w_valid_early1", int'(host_rd_valid), 0);
      host_rd_req = 1'b0;
      tick();
      chk("w_valid_req0", int'(host_rd_valid), 1);
      tick();
      chk("w_valid_req1", int'(host_rd_valid), 1);
      tick();
      chk("w_valid_idle", int'(host_rd_valid), 0);

      // re-arm while a read is in flight: its valid still completes
      host_rd_req = 1'b1; host_rd_offset = 4'd3;
      tick();
      chk("ra_addrb", int'(bram_addrb), 11);
      host_rd_req = 1'b0;
      pulse_arm();
      tick();
      chk("ra_valid", int'(host_rd_valid), 1);
      chk("ra_state", int'(state), 1);

      // trigger with coincident sample, post_count=1
      samples(2);
      trigger = 1'b1; sample_valid = 1'b1; post_count = 4'd1;
      tick();
      trigger = 1'b0; sample_valid = 1'b0;
      chk("tc_we", int'(bram_we), 1);
      chk("tc_addra", int'(bram_addra), 2);
      chk("tc_state", int'(state), 3);
      chk("tc_trig_addr", int'(trig_addr), 2);
      tick();
      chk("tc_we_after", int'(bram_we), 0);
      samples(2);
      chk("tc_captured", int'(captured), 3);

      // post_count = 0 at trigger
      pulse_arm();
      samples(3);
      do_trigger(0);
      chk("pc0_state", int'(state), 3);
      chk("pc0_we", int'(bram_we), 0);
      samples(3);
      chk("pc0_captured", int'(captured), 3);
      chk("pc0_addra", int'(bram_addra), 2);

      // abort + arm in POST, then reads in IDLE
      pulse_arm();
      samples(2);
      do_trigger(5);
      samples(1);
      sample_valid = 1'b1; abort = 1'b1; arm = 1'b1;
      tick();
      sample_valid = 1'b0; abort = 1'b0; arm = 1'b0;
      chk("ab_state", int'(state), 0);
      chk("ab_we", int'(bram_we), 0);
      host_rd_req = 1'b1;
      tick(); tick(); tick();
      host_rd_req = 1'b0;
      tick();
      chk("ab_rd_valid", int'(host_rd_valid), 0);

      // async reset mid-POST
      pulse_arm();
      samples(2);
      do_trigger(6);
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      rstn = 1'b0;
      #1;
      chk("ar_state", int'(state), 0);
      chk("ar_we", int'(bram_we), 0);
      chk("ar_addra", int'(bram_addra), 0);
      chk("ar_trig_addr", int'(trig_addr), 0);
      chk("ar_done", int'(done), 0);
      chk("ar_bram_en", int'(bram_en), 1);
      tick(); tick();
      rstn = 1'b1;
      tick();
      pulse_arm();
      samples(2);
      do_trigger(2);
      samples(2);
      chk("ar_post_done", int'(done), 1);
      chk("ar_post_captured", int'(captured), 4);
      chk("ar_post_trig", int'(trig_addr), 2);
      tick(); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
